// File: rtl/cache_wb_assoc_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_wb_assoc_if : CPU-side and main-memory-side signals of the |
// | set-associative write-back cache.                    Rev 1.0      |
// +------------------------------------------------------------------+
interface cache_wb_assoc_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int C_LINE_W = LINE_WORDS * DATA_W;

    logic                read;
    logic                write;
    logic [ADDR_W-1:0]   memoryaddress;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                hit;
    logic                stall;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [C_LINE_W-1:0] mem_wdata;
    logic [C_LINE_W-1:0] mem_rdata;
    logic                mem_ready;
    logic [31:0]         hit_count;
    logic [31:0]         miss_count;
    logic [31:0]         wb_count;

    // Cache side
    modport slave (
        input  read, write, memoryaddress, writedata, mem_rdata, mem_ready,
        output readdata, hit, stall, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count, wb_count
    );

    // Pipeline / memory-model side
    modport master (
        output read, write, memoryaddress, writedata, mem_rdata, mem_ready,
        input  readdata, hit, stall, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count, wb_count
    );
endinterface
`default_nettype wire

// File: rtl/cache_wb_assoc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_wb_assoc : N-way write-back/write-allocate data cache with |
// | miss FSM. Define CACHE_STATS_EN for hit/miss/writeback counters. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cache_wb_assoc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic clk,
    input  logic reset,
    cache_wb_assoc_if.slave bus
);
    localparam int C_LINE_W   = LINE_WORDS * DATA_W;
    localparam int C_OFF_W    = $clog2(C_LINE_W / 8);
    localparam int C_WORD_LSB = $clog2(DATA_W / 8);
    localparam int C_WSEL_W   = $clog2(LINE_WORDS);
    localparam int C_IDX_W    = $clog2(SETS);
    localparam int C_TAG_W    = ADDR_W - C_IDX_W - C_OFF_W;
    localparam int C_WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [C_WAY_W-1:0]    ptr_q   [SETS];
    logic [C_TAG_W-1:0]    tag_mem [SETS][WAYS];
    logic [C_LINE_W-1:0]   data_mem[SETS][WAYS];
    logic [C_WAY_W-1:0]    vic_q;
    logic [C_IDX_W-1:0]    idx_q;
    logic [C_TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]     rdata_q;

    logic [C_IDX_W-1:0]    w_idx, w_wr_set;
    logic [C_TAG_W-1:0]    w_tag;
    logic [C_WSEL_W-1:0]   w_word;
    logic                  w_req, w_hit_any, w_vic_from_ptr;
    logic [C_WAY_W-1:0]    w_hit_way, w_vic, w_wr_way;
    logic                  w_hit, w_stall, w_mem_req, w_mem_we;
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [C_LINE_W-1:0]   w_mem_wdata, w_rd_line;
    logic                  w_idle_hit, w_miss, w_wb_done, w_fill, w_word_we, w_rd_sel;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_unused_lsb;

    assign w_idx        = bus.memoryaddress[C_OFF_W +: C_IDX_W];
    assign w_tag        = bus.memoryaddress[ADDR_W-1 -: C_TAG_W];
    assign w_word       = bus.memoryaddress[C_WORD_LSB +: C_WSEL_W];
    assign w_req        = bus.read | bus.write;
    assign w_unused_lsb = ^bus.memoryaddress[C_WORD_LSB-1:0];

    // Tag compare and victim choice: lowest invalid way wins over the pointer.
    always_comb begin
        w_hit_any      = 1'b0;
        w_hit_way      = '0;
        w_vic          = ptr_q[w_idx];
        w_vic_from_ptr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w_idx][w] && (tag_mem[w_idx][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = C_WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w_idx][w]) begin
                w_vic          = C_WAY_W'(w);
                w_vic_from_ptr = 1'b0;
            end
        end
    end

    // All outputs are qualified with reset so they drop the moment it asserts.
    always_comb begin
        state_d     = state_q;
        w_hit       = 1'b0;
        w_stall     = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_idle_hit  = 1'b0;
        w_miss      = 1'b0;
        w_wb_done   = 1'b0;
        w_fill      = 1'b0;
        w_word_we   = 1'b0;
        w_wr_way    = w_hit_way;
        w_wr_set    = w_idx;
        w_rd_line   = data_mem[w_idx][w_hit_way];
        if (reset) begin
            case (state_q)
                S_IDLE: begin
                    if (w_req && w_hit_any) begin
                        w_hit      = 1'b1;
                        w_idle_hit = 1'b1;
                        w_word_we  = bus.write;
                    end else if (w_req) begin
                        w_stall = 1'b1;
                        w_miss  = 1'b1;
                        state_d = (w_vic_from_ptr && dirty_q[w_idx][w_vic]) ? S_WB : S_REFILL;
                    end
                end
                S_WB: begin
                    w_stall     = 1'b1;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = {tag_mem[idx_q][vic_q], idx_q, {C_OFF_W{1'b0}}};
                    w_mem_wdata = data_mem[idx_q][vic_q];
                    if (bus.mem_ready) begin
                        w_wb_done = 1'b1;
                        state_d   = S_REFILL;
                    end
                end
                S_REFILL: begin
                    w_stall    = 1'b1;
                    w_mem_req  = 1'b1;
                    w_mem_addr = {tag_q, idx_q, {C_OFF_W{1'b0}}};
                    if (bus.mem_ready) begin
                        w_fill  = 1'b1;
                        state_d = S_RESP;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    w_hit     = w_req;
                    w_word_we = bus.write;
                    w_wr_way  = vic_q;
                    w_wr_set  = idx_q;
                    w_rd_line = data_mem[idx_q][vic_q];
                end
            endcase
        end
    end

    assign w_rd_sel  = w_hit & bus.read & ~bus.write;
    assign w_rd_word = w_rd_line[w_word*DATA_W +: DATA_W];

    assign bus.hit       = w_hit;
    assign bus.stall     = w_stall;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.readdata  = w_rd_sel ? w_rd_word : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            vic_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            ptr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            if (w_miss) begin
                vic_q <= w_vic;
                idx_q <= w_idx;
                tag_q <= w_tag;
                if (w_vic_from_ptr)
                    ptr_q[w_idx] <= (ptr_q[w_idx] == C_WAY_W'(WAYS - 1)) ? '0 : ptr_q[w_idx] + 1'b1;
            end
            if (w_fill) begin
                valid_q[idx_q][vic_q] <= 1'b1;
                dirty_q[idx_q][vic_q] <= 1'b0;
            end
            if (w_word_we)
                dirty_q[w_wr_set][w_wr_way] <= 1'b1;
            if (w_rd_sel)
                rdata_q <= w_rd_word;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tag_mem[idx_q][vic_q]  <= tag_q;
            data_mem[idx_q][vic_q] <= bus.mem_rdata;
        end
        if (w_word_we)
            data_mem[w_wr_set][w_wr_way][w_word*DATA_W +: DATA_W] <= bus.writedata;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (w_idle_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (w_miss)     miss_cnt_q <= miss_cnt_q + 32'd1;
            if (w_wb_done)  wb_cnt_q   <= wb_cnt_q + 32'd1;
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
    assign bus.wb_count   = wb_cnt_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_idle_hit ^ w_wb_done;
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
    assign bus.wb_count   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_wb_assoc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cache_wb_assoc : directed self-checking bench for the         |
// | set-associative write-back cache.                     Rev 1.0    |
// +------------------------------------------------------------------+
module tb_cache_wb_assoc;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [127:0] LINE_A = 128'h0000000C_00000008_00000004_00000000;
    localparam logic [127:0] LINE_B = 128'h40000003_40000002_40000001_40000000;
    localparam logic [127:0] LINE_C = 128'h80000003_80000002_80000001_80000000;
    localparam logic [127:0] LINE_D = 128'hB0000003_B0000002_B0000001_B0000000;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    cache_wb_assoc_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) bus ();

    cache_wb_assoc #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(64), .WAYS(2)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.read          = rd;
        bus.write         = wr;
        bus.memoryaddress = a;
        bus.writedata     = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %0b exp 0", bus.hit); end
        n_chk++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b exp 0", bus.stall); end
        n_chk++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %0b exp 0", bus.mem_req); end
        n_chk++; if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL rst_readdata: got %h exp 0", bus.readdata); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_clean_miss;
        drive(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        bus.mem_rdata = LINE_A;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1 || bus.hit !== 1'b0) begin n_err++; $display("FAIL cm_detect: stall=%0b hit=%0b exp 1/0", bus.stall, bus.hit); end
        n_chk++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cm_idle_req: got %0b exp 0", bus.mem_req); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL cm_refill: stall=%0b req=%0b we=%0b exp 1/1/0", bus.stall, bus.mem_req, bus.mem_we); end
        n_chk++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL cm_refill_addr: got %h exp 0", bus.mem_addr); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cm_respond: hit=%0b stall=%0b req=%0b exp 1/0/0", bus.hit, bus.stall, bus.mem_req); end
        n_chk++; if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL cm_readdata: got %h exp 0", bus.readdata); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b0 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cm_idle: hit=%0b stall=%0b req=%0b exp 0/0/0", bus.hit, bus.stall, bus.mem_req); end
    endtask

    task automatic test_write_hit;
        tick;
        drive(1'b0, 1'b1, 32'h0000_0004, 32'h1111_1111);
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.stall !== 1'b0) begin n_err++; $display("FAIL wh_write: hit=%0b stall=%0b exp 1/0", bus.hit, bus.stall); end
        tick;
        drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1) begin n_err++; $display("FAIL wh_read_hit: got %0b exp 1", bus.hit); end
        n_chk++; if (bus.readdata !== 32'h1111_1111) begin n_err++; $display("FAIL wh_read_data: got %h exp 11111111", bus.readdata); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.readdata !== 32'h1111_1111 || bus.hit !== 1'b0) begin n_err++; $display("FAIL wh_hold: data=%h hit=%0b exp 11111111/0", bus.readdata, bus.hit); end
    endtask

    task automatic test_dirty_evict;
        tick;
        drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        bus.mem_rdata = LINE_B;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL de_miss1: got %0b exp 1", bus.stall); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0000_0400) begin n_err++; $display("FAIL de_refill1: we=%0b addr=%h exp 0/00000400", bus.mem_we, bus.mem_addr); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'h4000_0000) begin n_err++; $display("FAIL de_resp1: hit=%0b data=%h exp 1/40000000", bus.hit, bus.readdata); end
        tick;
        drive(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        bus.mem_rdata = LINE_C;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL de_miss2: stall=%0b req=%0b exp 1/0", bus.stall, bus.mem_req); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL de_wb: req=%0b we=%0b addr=%h exp 1/1/0", bus.mem_req, bus.mem_we, bus.mem_addr); end
        n_chk++; if (bus.mem_wdata !== 128'h0000000C_00000008_11111111_00000000) begin n_err++; $display("FAIL de_wb_data: got %h exp 0000000c000000081111111100000000", bus.mem_wdata); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0000_0800 || bus.stall !== 1'b1) begin n_err++; $display("FAIL de_refill2: we=%0b addr=%h stall=%0b exp 0/00000800/1", bus.mem_we, bus.mem_addr, bus.stall); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'h8000_0000) begin n_err++; $display("FAIL de_resp2: hit=%0b data=%h exp 1/80000000", bus.hit, bus.readdata); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_stats;
        @(negedge clk);
        n_chk++; if (bus.hit_count !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL st_hits: got %0d exp %0d", bus.hit_count, STATS ? 2 : 0); end
        n_chk++; if (bus.miss_count !== (STATS ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL st_misses: got %0d exp %0d", bus.miss_count, STATS ? 3 : 0); end
        n_chk++; if (bus.wb_count !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL st_wbs: got %0d exp %0d", bus.wb_count, STATS ? 1 : 0); end
    endtask

    task automatic test_slow_memory;
        tick;
        drive(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'h4000_0001) begin n_err++; $display("FAIL sm_way1_hit: hit=%0b data=%h exp 1/40000001", bus.hit, bus.readdata); end
        tick;
        drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
        bus.mem_rdata = LINE_A;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL sm_miss: got %0b exp 1", bus.stall); end
        for (int c = 0; c < 5; c++) begin
            tick;
            @(negedge clk);
            n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.stall !== 1'b1) begin n_err++; $display("FAIL sm_wait%0d: req=%0b we=%0b addr=%h stall=%0b exp 1/0/0/1", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall); end
        end
        tick;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b1 || bus.stall !== 1'b1) begin n_err++; $display("FAIL sm_ready: req=%0b stall=%0b exp 1/1", bus.mem_req, bus.stall); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'h0000_0008) begin n_err++; $display("FAIL sm_resp: hit=%0b data=%h exp 1/00000008", bus.hit, bus.readdata); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_refill;
        tick;
        drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        bus.mem_ready = 1'b0;
        tick;
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rr_in_refill: got %0b exp 1", bus.mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.hit !== 1'b0) begin n_err++; $display("FAIL rr_async: req=%0b stall=%0b hit=%0b exp 0/0/0", bus.mem_req, bus.stall, bus.hit); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick;
        drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        bus.mem_rdata = LINE_A;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1 || bus.hit !== 1'b0) begin n_err++; $display("FAIL rr_remiss: stall=%0b hit=%0b exp 1/0", bus.stall, bus.hit); end
        tick;
        tick;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'h0000_0004) begin n_err++; $display("FAIL rr_resp: hit=%0b data=%h exp 1/00000004", bus.hit, bus.readdata); end
        n_chk++; if (bus.miss_count !== (STATS ? 32'd1 : 32'd0) || bus.hit_count !== 32'd0) begin n_err++; $display("FAIL rr_stats: miss=%0d hit=%0d exp %0d/0", bus.miss_count, bus.hit_count, STATS ? 1 : 0); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_write_miss;
        tick;
        drive(1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        bus.mem_rdata = LINE_D;
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b1 || bus.hit !== 1'b0) begin n_err++; $display("FAIL wm_miss: stall=%0b hit=%0b exp 1/0", bus.stall, bus.hit); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.mem_addr !== 32'h0000_1000 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL wm_refill: addr=%h we=%0b exp 00001000/0", bus.mem_addr, bus.mem_we); end
        tick;
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.stall !== 1'b0) begin n_err++; $display("FAIL wm_resp: hit=%0b stall=%0b exp 1/0", bus.hit, bus.stall); end
        tick;
        drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wm_merged: hit=%0b data=%h exp 1/deadbeef", bus.hit, bus.readdata); end
        tick;
        drive(1'b1, 1'b0, 32'h0000_1008, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.hit !== 1'b1 || bus.readdata !== 32'hB000_0002) begin n_err++; $display("FAIL wm_other_word: hit=%0b data=%h exp 1/b0000002", bus.hit, bus.readdata); end
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.readdata !== 32'hB000_0002 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin n_err++; $display("FAIL wm_idle: data=%h req=%0b stall=%0b exp b0000002/0/0", bus.readdata, bus.mem_req, bus.stall); end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset;
        test_clean_miss;
        test_write_hit;
        test_dirty_evict;
        test_stats;
        test_slow_memory;
        test_reset_mid_refill;
        test_write_miss;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
